// File: rtl/maxicore32_pkg.sv
// Shared definitions for the maxicore32 multi-cycle load/store core:
// opcodes, ALU and branch-condition encodings, FSM states, instruction fields.
package maxicore32_pkg;

  localparam logic [5:0] OP_NOP       = 6'h00;
  localparam logic [5:0] OP_HALT      = 6'h01;
  localparam logic [5:0] OP_LOADI     = 6'h02;
  localparam logic [5:0] OP_LOADUPPER = 6'h03;
  localparam logic [5:0] OP_LOADW     = 6'h04;
  localparam logic [5:0] OP_LOADH     = 6'h05;
  localparam logic [5:0] OP_LOADB     = 6'h06;
  localparam logic [5:0] OP_STOREW    = 6'h08;
  localparam logic [5:0] OP_STOREH    = 6'h09;
  localparam logic [5:0] OP_STOREB    = 6'h0A;
  localparam logic [5:0] OP_BRANCH    = 6'h20;
  localparam logic [5:0] OP_JUMP      = 6'h21;

  // Low opcode bits of loads/stores give the access size.
  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  localparam logic [3:0] COND_ALWAYS = 4'd0;
  localparam logic [3:0] COND_EQ     = 4'd1;
  localparam logic [3:0] COND_NE     = 4'd2;
  localparam logic [3:0] COND_CS     = 4'd3;
  localparam logic [3:0] COND_CC     = 4'd4;
  localparam logic [3:0] COND_MI     = 4'd5;
  localparam logic [3:0] COND_PL     = 4'd6;

  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RD_LSB     = 22;
  localparam int unsigned RS1_LSB    = 18;
  localparam int unsigned RS2_LSB    = 14;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR, ALU_ASR
  } alu_op_t;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEM, ST_WB, ST_STOP
  } state_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/maxicore32_alu.sv
// Combinational ALU: eight operations with zero/negative/carry flags.
module maxicore32_alu
  import maxicore32_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] result,
  output logic        z,
  output logic        n,
  output logic        c
);

  logic [4:0] shamt;

  assign shamt = b[4:0];

  // Shifts run through a 33-bit window so the last bit shifted out lands in c.
  always_comb begin
    result = '0;
    c      = 1'b0;
    case (op)
      ALU_ADD: {c, result} = {1'b0, a} + {1'b0, b};
      ALU_SUB: {c, result} = {1'b0, a} - {1'b0, b};
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SHL: {c, result} = {1'b0, a} << shamt;
      ALU_SHR: {result, c} = {a, 1'b0} >> shamt;
      ALU_ASR: {result, c} = $signed({a, 1'b0}) >>> shamt;
      default: result = '0;
    endcase
    z = (result == '0);
    n = result[31];
  end

endmodule

// File: rtl/maxicore32_core.sv
// maxicore32 multi-cycle core: FETCH/DECODE/EXECUTE[/MEM[/WB]] over one shared
// 32-bit bus with big-endian byte strobes; freezes on halt or misaligned access.
module maxicore32_core
  import maxicore32_pkg::*;
#(
  parameter logic [29:0] RESET_PC = 30'h0
) (
  input  logic        clock,
  input  logic        reset,
  output logic [29:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic [3:0]  data_strobes,
  output logic        read,
  output logic        write,
  output logic        bus_error,
  output logic        halted,
  output logic [5:0]  user
);

  state_t      state, state_next;
  logic [29:0] program_counter;
  logic [31:0] register_file [16];
  logic [31:0] ir, ea;
  logic        flag_z, flag_n, flag_c;

  logic [5:0]  opcode;
  logic [3:0]  rd, rs1, rs2;
  logic [15:0] imm;
  logic [31:0] sext_imm, rd_val, rs1_val, rs2_val, ea_calc;
  logic [1:0]  mem_size;
  logic        is_load, is_store, is_alu, legal, misaligned, branch_taken;
  logic [31:0] alu_result;
  logic        alu_z, alu_n, alu_c;
  logic [31:0] load_value, store_data;
  logic [3:0]  mem_strobes;

  assign opcode   = ir[OPCODE_LSB +: 6];
  assign rd       = ir[RD_LSB +: 4];
  assign rs1      = ir[RS1_LSB +: 4];
  assign rs2      = ir[RS2_LSB +: 4];
  assign imm      = ir[15:0];
  assign sext_imm = sext16(imm);
  assign rd_val   = register_file[rd];
  assign rs1_val  = register_file[rs1];
  assign rs2_val  = register_file[rs2];
  assign ea_calc  = rs1_val + sext_imm;
  assign mem_size = opcode[1:0];
  assign user     = opcode;

  assign is_load  = (opcode == OP_LOADW) || (opcode == OP_LOADH) || (opcode == OP_LOADB);
  assign is_store = (opcode == OP_STOREW) || (opcode == OP_STOREH) || (opcode == OP_STOREB);
  assign is_alu   = (opcode[5:4] == 2'b01);
  assign legal    = is_load || is_store || is_alu || (opcode == OP_NOP) || (opcode == OP_HALT) ||
                    (opcode == OP_LOADI) || (opcode == OP_LOADUPPER) ||
                    (opcode == OP_BRANCH) || (opcode == OP_JUMP);
  assign misaligned = ((mem_size == SIZE_WORD) && (ea_calc[1:0] != 2'b00)) ||
                      ((mem_size == SIZE_HALF) && ea_calc[0]);

  maxicore32_alu u_alu (
    .a      (rs1_val),
    .b      (opcode[3] ? sext_imm : rs2_val),
    .op     (alu_op_t'(opcode[2:0])),
    .result (alu_result),
    .z      (alu_z),
    .n      (alu_n),
    .c      (alu_c)
  );

  always_comb begin
    case (rd)
      COND_ALWAYS: branch_taken = 1'b1;
      COND_EQ:     branch_taken = flag_z;
      COND_NE:     branch_taken = !flag_z;
      COND_CS:     branch_taken = flag_c;
      COND_CC:     branch_taken = !flag_c;
      COND_MI:     branch_taken = flag_n;
      COND_PL:     branch_taken = !flag_n;
      default:     branch_taken = 1'b0;
    endcase
  end

  // Byte offset 0 is the most significant lane.
  always_comb begin
    mem_strobes = '0;
    store_data  = '0;
    load_value  = '0;
    case (mem_size)
      SIZE_WORD: begin
        mem_strobes = '1;
        store_data  = rd_val;
        load_value  = data_in;
      end
      SIZE_HALF: begin
        mem_strobes = ea[1] ? 4'b0011 : 4'b1100;
        store_data  = {2{rd_val[15:0]}};
        load_value  = {16'h0, ea[1] ? data_in[15:0] : data_in[31:16]};
      end
      SIZE_BYTE: begin
        mem_strobes = 4'b1000 >> ea[1:0];
        store_data  = {4{rd_val[7:0]}};
        load_value  = {24'h0, data_in[(5'd24 - {ea[1:0], 3'b000}) +: 8]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH:   state_next = ST_DECODE;
      ST_DECODE:  state_next = ST_EXECUTE;
      ST_EXECUTE: begin
        if (!legal || (opcode == OP_HALT))  state_next = ST_STOP;
        else if (is_load || is_store)       state_next = misaligned ? ST_STOP : ST_MEM;
        else                                state_next = ST_FETCH;
      end
      ST_MEM:     state_next = is_load ? ST_WB : ST_FETCH;
      ST_WB:      state_next = ST_FETCH;
      default:    state_next = ST_STOP;
    endcase
  end

  // Bus outputs are forced idle while reset is held, even though the state is FETCH.
  always_comb begin
    address      = '0;
    read         = 1'b0;
    write        = 1'b0;
    data_strobes = '0;
    data_out     = '0;
    if (reset) begin
      case (state)
        ST_FETCH: begin
          address      = program_counter;
          read         = 1'b1;
          data_strobes = '1;
        end
        ST_MEM: begin
          address      = ea[31:2];
          data_strobes = mem_strobes;
          if (is_store) begin
            write    = 1'b1;
            data_out = store_data;
          end else begin
            read = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      program_counter <= RESET_PC;
      for (int unsigned i = 0; i < 16; i++) register_file[i] <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      ir        <= '0;
      ea        <= '0;
      halted    <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      case (state)
        ST_DECODE: begin
          ir              <= data_in;
          program_counter <= program_counter + 30'd1;
        end
        ST_EXECUTE: begin
          ea <= ea_calc;
          if (is_alu) begin
            register_file[rd] <= alu_result;
            flag_z <= alu_z;
            flag_n <= alu_n;
            flag_c <= alu_c;
          end
          case (opcode)
            OP_HALT:      halted <= 1'b1;
            OP_LOADI:     register_file[rd] <= sext_imm;
            OP_LOADUPPER: register_file[rd] <= {imm, rd_val[15:0]};
            OP_BRANCH:    if (branch_taken) program_counter <= program_counter + sext_imm[29:0];
            OP_JUMP:      program_counter <= rs1_val[31:2];
            default: ;
          endcase
          if (!legal) halted <= 1'b1;
          if ((is_load || is_store) && misaligned) bus_error <= 1'b1;
        end
        ST_WB: register_file[rd] <= load_value;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maxicore32_core.sv
// Self-checking bench for maxicore32_core: table-driven ALU vectors plus
// directed programs for memory, branch, jump, LED and fault corner cases.
module tb_maxicore32_core;
  import maxicore32_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [29:0] address;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic [3:0]  data_strobes;
  logic        read, write, bus_error, halted;
  logic [5:0]  user;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [1024];
  int          read_count, write_count, fetch_at1, led_writes, rw_both;
  logic [29:0] last_waddr;
  logic [3:0]  last_wstrb;
  logic [31:0] last_wdata, led_value;
  int          cycles;

  maxicore32_core #(.RESET_PC(30'h0)) dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .data_in      (data_in),
    .data_out     (data_out),
    .data_strobes (data_strobes),
    .read         (read),
    .write        (write),
    .bus_error    (bus_error),
    .halted       (halted),
    .user         (user)
  );

  always #5 clock = ~clock;

  // Synchronous RAM in the 0x00 region, LED register at 0xFF.
  always @(posedge clock) begin
    if (read && write) rw_both++;
    if (read) begin
      data_in <= mem[address[9:0]];
      read_count++;
      if (address == 30'd1) fetch_at1++;
    end
    if (write) begin
      write_count++;
      last_waddr = address;
      last_wstrb = data_strobes;
      last_wdata = data_out;
      if (address[29:22] == 8'hFF) begin
        led_value = data_out;
        led_writes++;
      end else begin
        for (int i = 0; i < 4; i++)
          if (data_strobes[i]) mem[address[9:0]][8*i +: 8] = data_out[8*i +: 8];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] it(input logic [5:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, 2'b00, imm};
  endfunction

  function automatic logic [31:0] rt(input logic [5:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [3:0] rs2);
    return {op, rd, rs1, rs2, 14'h0};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = '0;
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic release_reset();
    read_count = 0; write_count = 0; fetch_at1 = 0; led_writes = 0;
    last_waddr = '0; last_wstrb = '0; last_wdata = '0; led_value = '0;
    reset = 1'b1;
  endtask

  task automatic wait_stop(input string name, input int budget);
    cycles = 0;
    while (!(halted || bus_error) && cycles < budget) begin
      @(posedge clock);
      cycles++;
      #1;
    end
    if (!(halted || bus_error)) begin
      errors++;
      $display("FAIL %s_timeout: no halt/bus_error after %0d cycles, expected stop", name, cycles);
    end
    @(negedge clock);
  endtask

  task automatic run_prog(input string name);
    hold_reset();
    release_reset();
    wait_stop(name, 300);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, res;
    logic [2:0]  znc;
  } alu_vec_t;

  alu_vec_t vec [12];

  initial begin
    vec[0]  = '{3'd0, 32'h00000005, 32'h00000007, 32'h0000000C, 3'b000};
    vec[1]  = '{3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 3'b101};
    vec[2]  = '{3'd1, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 3'b011};
    vec[3]  = '{3'd1, 32'h00000007, 32'h00000007, 32'h00000000, 3'b100};
    vec[4]  = '{3'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 3'b000};
    vec[5]  = '{3'd3, 32'h12340000, 32'h00005678, 32'h12345678, 3'b000};
    vec[6]  = '{3'd4, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 3'b000};
    vec[7]  = '{3'd5, 32'h80000001, 32'h00000001, 32'h00000002, 3'b001};
    vec[8]  = '{3'd6, 32'h00000003, 32'h00000001, 32'h00000001, 3'b001};
    vec[9]  = '{3'd7, 32'h80000000, 32'h00000004, 32'hF8000000, 3'b010};
    vec[10] = '{3'd5, 32'h80000000, 32'h00000020, 32'h80000000, 3'b010};
    vec[11] = '{3'd7, 32'h80000010, 32'h00000005, 32'hFC000000, 3'b011};

    // Reset state and first fetch, then ADD program.
    clear_mem();
    mem[0] = it(OP_LOADI, 4'd1, 4'd0, 16'd5);
    mem[1] = it(OP_LOADI, 4'd2, 4'd0, 16'd7);
    mem[2] = rt(6'h10, 4'd3, 4'd1, 4'd2);
    mem[3] = it(OP_HALT, 4'd0, 4'd0, 16'h0);
    hold_reset();
    check("reset_ctl", {28'h0, read, write, halted, bus_error}, 32'h0);
    check("reset_addr", {2'b00, address}, 32'h0);
    check("reset_bus", data_out | {28'h0, data_strobes}, 32'h0);
    check("reset_pc_user", {dut.program_counter, user}, 36'h0);
    release_reset();
    #1;
    check("first_fetch", {read, write, data_strobes, address[3:0]}, {1'b1, 1'b0, 4'hF, 4'h0});
    wait_stop("add", 300);
    check("add_cycles", cycles, 12);
    check("add_r3", dut.register_file[3], 32'h0000000C);
    check("add_halt", {halted, bus_error}, 2'b10);

    for (int v = 0; v < 12; v++) begin
      clear_mem();
      mem[0] = it(OP_LOADI, 4'd1, 4'd0, vec[v].a[15:0]);
      mem[1] = it(OP_LOADUPPER, 4'd1, 4'd0, vec[v].a[31:16]);
      mem[2] = it(OP_LOADI, 4'd2, 4'd0, vec[v].b[15:0]);
      mem[3] = it(OP_LOADUPPER, 4'd2, 4'd0, vec[v].b[31:16]);
      mem[4] = rt({3'b010, vec[v].op}, 4'd3, 4'd1, 4'd2);
      mem[5] = it(OP_HALT, 4'd0, 4'd0, 16'h0);
      run_prog($sformatf("alu%0d", v));
      check($sformatf("alu%0d_res", v), dut.register_file[3], vec[v].res);
      check($sformatf("alu%0d_znc", v), {dut.flag_z, dut.flag_n, dut.flag_c}, vec[v].znc);
    end

    // Word store and word/half loads.
    clear_mem();
    mem[0] = it(OP_LOADI, 4'd1, 4'd0, 16'h1234);
    mem[1] = it(OP_LOADUPPER, 4'd1, 4'd0, 16'hABCD);
    mem[2] = it(OP_STOREW, 4'd1, 4'd0, 16'h0040);
    mem[3] = it(OP_LOADW, 4'd5, 4'd0, 16'h0040);
    mem[4] = it(OP_LOADH, 4'd6, 4'd0, 16'h0042);
    mem[5] = it(OP_HALT, 4'd0, 4'd0, 16'h0);
    run_prog("storew");
    check("storew_mem", mem[16], 32'hABCD1234);
    check("storew_pulse", {write_count[3:0], last_wstrb}, {4'd1, 4'hF});
    check("loadw_r5", dut.register_file[5], 32'hABCD1234);
    check("loadh_r6", dut.register_file[6], 32'h00001234);
    check("storew_cycles", cycles, 23);

    // Byte store and byte load-back.
    clear_mem();
    mem[16] = 32'h11223344;
    mem[0] = it(OP_LOADI, 4'd1, 4'd0, 16'h00AA);
    mem[1] = it(OP_STOREB, 4'd1, 4'd0, 16'h0041);
    mem[2] = it(OP_LOADB, 4'd4, 4'd0, 16'h0041);
    mem[3] = it(OP_HALT, 4'd0, 4'd0, 16'h0);
    run_prog("storeb");
    check("storeb_strb", last_wstrb, 4'b0100);
    check("storeb_data", last_wdata, 32'hAAAAAAAA);
    check("storeb_mem", mem[16], 32'h11AA3344);
    check("loadb_r4", dut.register_file[4], 32'h000000AA);

    // Countdown loop.
    clear_mem();
    mem[0] = it(OP_LOADI, 4'd1, 4'd0, 16'd3);
    mem[1] = it(6'h19, 4'd1, 4'd1, 16'd1);
    mem[2] = it(OP_BRANCH, COND_NE, 4'd0, 16'hFFFE);
    mem[3] = it(OP_HALT, 4'd0, 4'd0, 16'h0);
    run_prog("loop");
    check("loop_r1", dut.register_file[1], 32'h0);
    check("loop_z", dut.flag_z, 1'b1);
    check("loop_body", fetch_at1, 3);
    check("loop_cycles", cycles, 24);

    // Misaligned word load freezes the core.
    clear_mem();
    mem[0] = it(OP_LOADW, 4'd2, 4'd0, 16'h0002);
    mem[1] = it(OP_HALT, 4'd0, 4'd0, 16'h0);
    run_prog("misalign");
    repeat (5) @(negedge clock);
    check("misalign_flags", {halted, bus_error}, 2'b01);
    check("misalign_reads", read_count, 1);
    check("misalign_pc", {2'b00, dut.program_counter}, 32'd1);

    // Halfword load at offset 2 is legal.
    clear_mem();
    mem[32] = 32'hCAFEBEEF;
    mem[0] = it(OP_LOADI, 4'd1, 4'd0, 16'h0080);
    mem[1] = it(OP_LOADH, 4'd3, 4'd1, 16'h0002);
    mem[2] = it(OP_HALT, 4'd0, 4'd0, 16'h0);
    run_prog("loadh");
    check("loadh_r3", dut.register_file[3], 32'h0000BEEF);
    check("loadh_flags", {halted, bus_error}, 2'b10);

    // LED store, then illegal opcode.
    clear_mem();
    mem[0] = it(OP_LOADI, 4'd1, 4'd0, 16'hFFFC);
    mem[1] = it(OP_LOADUPPER, 4'd1, 4'd0, 16'hFF00);
    mem[2] = it(OP_LOADI, 4'd2, 4'd0, 16'h005A);
    mem[3] = it(OP_STOREW, 4'd2, 4'd1, 16'h0000);
    mem[4] = 32'hFC000000;
    run_prog("led");
    check("led_write", {led_writes[3:0], last_waddr[29:22]}, {4'd1, 8'hFF});
    check("led_value", led_value, 32'h0000005A);
    check("illegal_flags", {halted, bus_error}, 2'b10);
    check("illegal_user", user, 6'h3F);

    // Register-indirect jump skips word 2.
    clear_mem();
    mem[0] = it(OP_LOADI, 4'd1, 4'd0, 16'h0010);
    mem[1] = rt(OP_JUMP, 4'd0, 4'd1, 4'd0);
    mem[2] = it(OP_LOADI, 4'd5, 4'd0, 16'd1);
    mem[3] = it(OP_HALT, 4'd0, 4'd0, 16'h0);
    mem[4] = it(OP_LOADI, 4'd5, 4'd0, 16'd9);
    mem[5] = it(OP_HALT, 4'd0, 4'd0, 16'h0);
    run_prog("jump");
    check("jump_r5", dut.register_file[5], 32'd9);
    check("jump_pc", {2'b00, dut.program_counter}, 32'd6);

    check("read_write_overlap", rw_both, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    rw_both = 0;
    #2000000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "global timeout");
  end

endmodule
